// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and small arithmetic helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MUL   = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF    = 5;
  localparam int DIV_CYCLES_DEF     = 10;
  localparam int CNT_W              = 8;
  localparam int DIV_BITS_PER_CYCLE = 4;
  localparam int DIV_ITERS          = 32 / DIV_BITS_PER_CYCLE;

  // Ops that hold the unit busy for more than one cycle.
  function automatic logic is_multi(input mdu_op_e op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL: is_multi = 1'b1;
      default:                                     is_multi = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    abs32 = (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Radix-16 restoring divider on magnitudes with sign fix-up; result is held
// from done until the next start.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;
  logic [31:0] r_dividend;
  logic [3:0]  r_iter;
  logic        r_done;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dvz;

  logic [31:0] w_quot_nxt;
  logic [31:0] w_rem_nxt;
  logic [32:0] w_shift;

  // Several restoring steps per cycle so 32 quotient bits fit the op latency.
  always_comb begin
    w_quot_nxt = r_quot;
    w_rem_nxt  = r_rem;
    w_shift    = 33'd0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      w_shift    = {w_rem_nxt, w_quot_nxt[31]};
      w_quot_nxt = {w_quot_nxt[30:0], 1'b0};
      if (w_shift >= {1'b0, r_dvsr}) begin
        w_rem_nxt     = 32'(w_shift - {1'b0, r_dvsr});
        w_quot_nxt[0] = 1'b1;
      end else begin
        w_rem_nxt = w_shift[31:0];
      end
    end
  end

  // Operand capture on start, then one radix-16 step per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_dvsr     <= 32'd0;
      r_dividend <= 32'd0;
      r_iter     <= 4'd0;
      r_done     <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvz      <= 1'b0;
    end else if (i_start) begin
      r_quot     <= abs32(i_dividend, i_signed);
      r_rem      <= 32'd0;
      r_dvsr     <= abs32(i_divisor, i_signed);
      r_dividend <= i_dividend;
      r_iter     <= 4'(DIV_ITERS);
      r_done     <= 1'b0;
      r_neg_q    <= i_signed & (i_dividend[31] ^ i_divisor[31]);
      r_neg_r    <= i_signed & i_dividend[31];
      r_dvz      <= (i_divisor == 32'd0);
    end else if (r_iter != 4'd0) begin
      r_quot <= w_quot_nxt;
      r_rem  <= w_rem_nxt;
      r_iter <= r_iter - 4'd1;
      r_done <= (r_iter == 4'd1);
    end else begin
      r_done <= r_done;
    end
  end

  // Divide-by-zero overrides; 0x80000000 / -1 falls out of the magnitude path.
  always_comb begin
    o_done = r_done;
    o_quot = r_dvz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_quot) : r_quot);
    o_rem  = r_dvz ? r_dividend    : (r_neg_r ? (32'd0 - r_rem)  : r_rem);
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO owner, fixed-latency MULT/MULTU/DIV/DIVU/MUL
// with a busy/ready handshake toward the pipeline and a MUL writeback port.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  dst_in,
  output logic        busy,
  output logic        ready,
  output logic        to_busy,
  output logic        rf_wr,
  output logic [4:0]  dst,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wb_valid,
  output logic [31:0] wb_data
);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mdu_op_e          r_op;
  logic [63:0]      r_prod;
  logic [4:0]       r_dst;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_wb_valid;
  logic [31:0]      r_wb_data;

  mdu_op_e          w_op;
  logic             w_accept;
  logic             w_multi;
  logic             w_is_div;
  logic             w_mul_signed;
  logic [63:0]      w_a_ext;
  logic [63:0]      w_b_ext;
  logic [63:0]      w_prod;
  logic             w_div_done;
  logic [31:0]      w_div_quot;
  logic [31:0]      w_div_rem;

  assign w_op         = mdu_op_e'(op);
  assign w_accept     = start & ~kill & ~busy;
  assign w_multi      = is_multi(w_op);
  assign w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_mul_signed = (w_op != OP_MULTU);
  assign w_a_ext      = {{32{w_mul_signed & a[31]}}, a};
  assign w_b_ext      = {{32{w_mul_signed & b[31]}}, b};
  assign w_prod       = w_a_ext * w_b_ext;
  assign to_busy      = start & ~kill & ~busy & w_multi;

  mdu_div u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_accept & w_is_div),
    .i_signed   (w_op == OP_DIV),
    .i_dividend (a),
    .i_divisor  (b),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = (w_accept && w_multi) ? ST_RUN : ST_IDLE;
      ST_RUN:  w_state_nxt = ready ? ST_IDLE : ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    rf_wr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy  = 1'b0;
        ready = 1'b0;
        rf_wr = 1'b0;
      end
      ST_RUN: begin
        busy  = 1'b1;
        ready = (r_cnt == CNT_W'(1));
        rf_wr = (r_op == OP_MUL);
      end
      default: begin
        busy  = 1'b0;
        ready = 1'b0;
        rf_wr = 1'b0;
      end
    endcase
  end

  // Latency counter plus operands/product captured at acceptance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_op   <= OP_MULT;
      r_prod <= 64'd0;
      r_dst  <= 5'd0;
    end else if (w_accept && w_multi) begin
      r_cnt  <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      r_op   <= w_op;
      r_prod <= w_prod;
      r_dst  <= (w_op == OP_MUL) ? dst_in : r_dst;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // HI/LO updates and the MUL writeback pulse one cycle after ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= 32'd0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && (w_op == OP_MTHI)) begin
        r_hi <= a;
      end else if (w_accept && (w_op == OP_MTLO)) begin
        r_lo <= a;
      end else if (ready) begin
        case (r_op)
          OP_MULT, OP_MULTU: {r_hi, r_lo} <= r_prod;
          OP_DIV, OP_DIVU: begin
            if (w_div_done) begin
              r_hi <= w_div_rem;
              r_lo <= w_div_quot;
            end
          end
          OP_MUL: begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= r_prod[31:0];
          end
          default: r_wb_valid <= 1'b0;
        endcase
      end
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign dst      = r_dst;
  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;

endmodule
